// File: rtl/dspl_pkg.sv
// Shared types, digit codes and digit-word packing for the display scheduler.
package dspl_pkg;

  typedef enum logic {
    SHOW_VAL = 1'b0,
    SHOW_MSG = 1'b1
  } state_e;

  localparam logic [3:0] CODE_0 = 4'h0;
  localparam logic [3:0] CODE_1 = 4'h1;
  localparam logic [3:0] CODE_2 = 4'h2;
  localparam logic [3:0] CODE_3 = 4'h3;
  localparam logic [3:0] CODE_4 = 4'h4;
  localparam logic [3:0] CODE_5 = 4'h5;
  localparam logic [3:0] CODE_6 = 4'h6;
  localparam logic [3:0] CODE_7 = 4'h7;
  localparam logic [3:0] CODE_8 = 4'h8;
  localparam logic [3:0] CODE_9 = 4'h9;
  localparam logic [3:0] CODE_P = 4'hA;
  localparam logic [3:0] CODE_B = 4'hB;
  localparam logic [3:0] CODE_C = 4'hC;
  localparam logic [3:0] CODE_S = 4'hD;
  localparam logic [3:0] CODE_E = 4'hE;
  localparam logic [3:0] CODE_U = 4'hF;

  localparam int unsigned DIGIT_W = 6;
  localparam int unsigned NUM_DIGITS = 8;

  // Driver digit word: {en, code, dp}.
  function automatic logic [DIGIT_W-1:0] pack_digit(input logic en, input logic [3:0] code,
                                                    input logic dp);
    return {en, code, dp};
  endfunction

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/dspl_hold_timer.sv
// Loadable cycle counter 0..N-1 with clear, enable and a registered terminal-count flag.
module dspl_hold_timer #(
  parameter int unsigned N = 2,
  parameter int unsigned W = 1
) (
  input  logic         clock_i,
  input  logic         reset_i,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         tc_o
);

  logic [W-1:0] cnt_q, cnt_d;
  logic         tc_q;

  // Clear wins over load, load over count; the count wraps after N-1.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i) begin
      cnt_d = tc_q ? '0 : cnt_q + W'(1);
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      cnt_q <= '0;
      tc_q  <= (N == 1);
    end else begin
      cnt_q <= cnt_d;
      tc_q  <= (cnt_d == W'(N - 1));
    end
  end

  assign tc_o = tc_q;

endmodule

// File: rtl/dspl_msg_sched.sv
// Shares the eight display digits between a live value and timed messages.
// Optional message blinking is built in when DSPL_BLINK_EN is defined.
module dspl_msg_sched
  import dspl_pkg::*;
#(
  parameter int unsigned CLK_PER_MS = 100000,
  parameter int unsigned HOLD_MS    = 2000,
  parameter int unsigned BLINK_MS   = 250
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] val_digits,
  input  logic [7:0]  val_en,
  input  logic        msg_req,
  input  logic [31:0] msg_digits,
  input  logic [7:0]  msg_en,
  input  logic        msg_clr,
  output logic        msg_ack,
  output logic        msg_busy,
  output logic [5:0]  d1,
  output logic [5:0]  d2,
  output logic [5:0]  d3,
  output logic [5:0]  d4,
  output logic [5:0]  d5,
  output logic [5:0]  d6,
  output logic [5:0]  d7,
  output logic [5:0]  d8
);

  localparam int unsigned HOLD_CYC  = HOLD_MS * CLK_PER_MS;
  localparam int unsigned HOLD_W    = cnt_w(HOLD_CYC);
  localparam int unsigned BLINK_CYC = BLINK_MS * CLK_PER_MS;

  state_e                   state_q;
  logic [31:0]              msg_digits_q;
  logic [7:0]               msg_en_q;
  logic [DIGIT_W-1:0]       d_q [NUM_DIGITS];
  logic                     ack_q;
  logic                     accept_c;
  logic                     in_msg_c;
  logic                     hold_tc;
  logic                     phase_c;

  assign in_msg_c = (state_q == SHOW_MSG);
  assign accept_c = (state_q == SHOW_VAL) && msg_req;

  dspl_hold_timer #(
    .N (HOLD_CYC),
    .W (HOLD_W)
  ) u_hold (
    .clock_i    (clock),
    .reset_i    (reset),
    .clr_i      (accept_c),
    .en_i       (in_msg_c),
    .load_i     (1'b0),
    .load_val_i ({HOLD_W{1'b0}}),
    .tc_o       (hold_tc)
  );

`ifdef DSPL_BLINK_EN
  localparam int unsigned BLINK_W = cnt_w(BLINK_CYC);

  logic blink_tc;
  logic phase_q;

  dspl_hold_timer #(
    .N (BLINK_CYC),
    .W (BLINK_W)
  ) u_blink (
    .clock_i    (clock),
    .reset_i    (reset),
    .clr_i      (accept_c),
    .en_i       (in_msg_c),
    .load_i     (1'b0),
    .load_val_i ({BLINK_W{1'b0}}),
    .tc_o       (blink_tc)
  );

  // Phase starts ON at acceptance and flips at each blink period end.
  always_ff @(posedge clock) begin
    if (reset) begin
      phase_q <= 1'b1;
    end else if (accept_c) begin
      phase_q <= 1'b1;
    end else if (in_msg_c && blink_tc) begin
      phase_q <= ~phase_q;
    end
  end

  // Phase that applies to the next message cycle.
  assign phase_c = phase_q ^ (in_msg_c && blink_tc);
`else
  // Steady message enables; BLINK_CYC is at least 1 so this is constant high.
  assign phase_c = (BLINK_CYC != 0);
`endif

  // Scheduler FSM with registered digit words and ack.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= SHOW_VAL;
      ack_q        <= 1'b0;
      msg_digits_q <= '0;
      msg_en_q     <= '0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
        d_q[k] <= '0;
      end
    end else begin
      ack_q <= accept_c;
      unique case (state_q)
        SHOW_VAL: begin
          if (msg_req) begin
            state_q      <= SHOW_MSG;
            msg_digits_q <= msg_digits;
            msg_en_q     <= msg_en;
            for (int k = 0; k < NUM_DIGITS; k++) begin
              d_q[k] <= pack_digit(msg_en[k], msg_digits[4*k +: 4], 1'b0);
            end
          end else begin
            for (int k = 0; k < NUM_DIGITS; k++) begin
              d_q[k] <= pack_digit(val_en[k], val_digits[4*k +: 4], 1'b0);
            end
          end
        end
        SHOW_MSG: begin
          if (msg_clr || hold_tc) begin
            state_q <= SHOW_VAL;
            for (int k = 0; k < NUM_DIGITS; k++) begin
              d_q[k] <= pack_digit(val_en[k], val_digits[4*k +: 4], 1'b0);
            end
          end else begin
            for (int k = 0; k < NUM_DIGITS; k++) begin
              d_q[k] <= pack_digit(msg_en_q[k] & phase_c, msg_digits_q[4*k +: 4], 1'b0);
            end
          end
        end
        default: state_q <= SHOW_VAL;
      endcase
    end
  end

  assign msg_ack  = ack_q;
  assign msg_busy = in_msg_c;
  assign d1 = d_q[0];
  assign d2 = d_q[1];
  assign d3 = d_q[2];
  assign d4 = d_q[3];
  assign d5 = d_q[4];
  assign d6 = d_q[5];
  assign d7 = d_q[6];
  assign d8 = d_q[7];

endmodule

// File: tb/tb_dspl_msg_sched.sv
// Randomized bench for dspl_msg_sched against a cycle-level behavioural model, plus directed pins.
module tb_dspl_msg_sched;

  localparam int unsigned CPM = 4;
  localparam int unsigned HMS = 3;
  localparam int unsigned BMS = 1;
  localparam int HOLD = HMS * CPM;
  localparam int BLK  = BMS * CPM;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] val_digits = '0;
  logic [7:0]  val_en = '0;
  logic        msg_req = 1'b0;
  logic [31:0] msg_digits = '0;
  logic [7:0]  msg_en = '0;
  logic        msg_clr = 1'b0;
  logic        msg_ack;
  logic        msg_busy;
  logic [5:0]  d1, d2, d3, d4, d5, d6, d7, d8;
  logic [5:0]  dut_d [8];

  int n_vec = 0;
  int n_err = 0;

  dspl_msg_sched #(
    .CLK_PER_MS (CPM),
    .HOLD_MS    (HMS),
    .BLINK_MS   (BMS)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .val_digits (val_digits),
    .val_en     (val_en),
    .msg_req    (msg_req),
    .msg_digits (msg_digits),
    .msg_en     (msg_en),
    .msg_clr    (msg_clr),
    .msg_ack    (msg_ack),
    .msg_busy   (msg_busy),
    .d1 (d1), .d2 (d2), .d3 (d3), .d4 (d4),
    .d5 (d5), .d6 (d6), .d7 (d7), .d8 (d8)
  );

  assign dut_d[0] = d1;
  assign dut_d[1] = d2;
  assign dut_d[2] = d3;
  assign dut_d[3] = d4;
  assign dut_d[4] = d5;
  assign dut_d[5] = d6;
  assign dut_d[6] = d7;
  assign dut_d[7] = d8;

  always #5 clock = ~clock;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Blink enable for message cycle 'age' (counted from 0 after acceptance).
  function automatic logic blink_on(input int age);
`ifdef DSPL_BLINK_EN
    return ((age / BLK) % 2) == 0;
`else
    return 1'b1;
`endif
  endfunction

  // Hand-computed blink pin for the test-plan parameters.
  function automatic logic pin_en(input int i);
`ifdef DSPL_BLINK_EN
    return (i < 4) || (i >= 8);
`else
    return 1'b1;
`endif
  endfunction

  // Behavioural model: who owns the display, and for how long.
  bit          m_busy = 1'b0;
  bit          m_ack = 1'b0;
  int          m_age = 0;
  logic [31:0] m_dig = '0;
  logic [7:0]  m_en = '0;
  logic [5:0]  exp_d [8];

  initial for (int k = 0; k < 8; k++) exp_d[k] = '0;

  function automatic void show_live();
    for (int k = 0; k < 8; k++) exp_d[k] = {val_en[k], val_digits[4*k +: 4], 1'b0};
  endfunction

  function automatic void show_msg();
    for (int k = 0; k < 8; k++) exp_d[k] = {m_en[k] & blink_on(m_age), m_dig[4*k +: 4], 1'b0};
  endfunction

  always @(posedge clock) begin
    if (reset) begin
      m_busy = 1'b0;
      m_ack  = 1'b0;
      m_age  = 0;
      for (int k = 0; k < 8; k++) exp_d[k] = '0;
    end else if (!m_busy) begin
      if (msg_req) begin
        m_busy = 1'b1;
        m_ack  = 1'b1;
        m_age  = 0;
        m_dig  = msg_digits;
        m_en   = msg_en;
        show_msg();
      end else begin
        m_ack = 1'b0;
        show_live();
      end
    end else begin
      m_ack = 1'b0;
      if (msg_clr || m_age == HOLD - 1) begin
        m_busy = 1'b0;
        show_live();
      end else begin
        m_age++;
        show_msg();
      end
    end
  end

  bit prev_ack = 1'b0;

  always @(negedge clock) begin
    for (int k = 0; k < 8; k++) check($sformatf("model_d%0d", k + 1), 32'(dut_d[k]), 32'(exp_d[k]));
    check("model_ack", 32'(msg_ack), 32'(m_ack));
    check("model_busy", 32'(msg_busy), 32'(m_busy));
    check("ack_consecutive", 32'(msg_ack & prev_ack), 32'd0);
    prev_ack = msg_ack;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    int acks;
    int first;
    int second;

    // Reset and live value
    repeat (3) tick();
    check("rst_d1", 32'(d1), 32'd0);
    check("rst_d8", 32'(d8), 32'd0);
    check("rst_busy", 32'(msg_busy), 32'd0);
    check("rst_ack", 32'(msg_ack), 32'd0);
    reset = 1'b0;
    val_digits = 32'h87654321;
    val_en = 8'hFF;
    tick();
    check("live_d1", 32'(d1), 32'b10_0010);
    check("live_d8", 32'(d8), 32'b11_0000);

    // Message accept and expiry
    msg_digits = 32'h0000FDDA;
    msg_en = 8'h0F;
    msg_req = 1'b1;
    tick();
    check("acc_ack", 32'(msg_ack), 32'd1);
    check("acc_busy", 32'(msg_busy), 32'd1);
    msg_req = 1'b0;
    cnt = 0;
    while (msg_busy && cnt < 50) begin
      check("msg_d1", 32'(d1), 32'({pin_en(cnt), 4'hA, 1'b0}));
      check("msg_d4", 32'(d4), 32'({pin_en(cnt), 4'hF, 1'b0}));
      check("msg_d5", 32'(d5), 32'd0);
      cnt++;
      tick();
    end
    check("hold_len", 32'(cnt), 32'd12);
    check("exp_d1", 32'(d1), 32'b10_0010);
    check("exp_ack", 32'(msg_ack), 32'd0);

    // Cancel at message cycle 5
    msg_req = 1'b1;
    tick();
    check("clr_acc", 32'(msg_ack), 32'd1);
    msg_req = 1'b0;
    repeat (5) tick();
    msg_clr = 1'b1;
    tick();
    msg_clr = 1'b0;
    check("clr_busy", 32'(msg_busy), 32'd0);
    check("clr_d1", 32'(d1), 32'b10_0010);
    acks = 0;
    repeat (5) begin
      tick();
      if (msg_ack) acks++;
    end
    check("clr_noack", 32'(acks), 32'd0);

    // Held request: 12 message cycles, one live cycle, next ack
    msg_req = 1'b1;
    first = -1;
    second = -1;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (msg_ack) begin
        if (first < 0) first = i;
        else if (second < 0) second = i;
      end
    end
    check("held_first", 32'(first), 32'd0);
    check("held_gap", 32'(second - first), 32'd13);
    msg_req = 1'b0;
    cnt = 0;
    while (msg_busy && cnt < 20) begin
      tick();
      cnt++;
    end
    check("held_drain", 32'(msg_busy), 32'd0);

    // Reset mid-message
    msg_req = 1'b1;
    tick();
    msg_req = 1'b0;
    repeat (6) tick();
    reset = 1'b1;
    tick();
    check("mid_rst_d1", 32'(d1), 32'd0);
    check("mid_rst_busy", 32'(msg_busy), 32'd0);
    reset = 1'b0;
    acks = 0;
    repeat (4) begin
      tick();
      if (msg_ack) acks++;
    end
    check("mid_rst_noack", 32'(acks), 32'd0);

    // Randomized traffic against the model
    for (int c = 0; c < 800; c++) begin
      reset = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 1) == 1) val_digits = $urandom;
      if ($urandom_range(0, 3) == 0) val_en = 8'($urandom);
      msg_clr = ($urandom_range(0, 15) == 0);
      if (msg_req) begin
        if (msg_ack) begin
          msg_req = ($urandom_range(0, 2) == 0);
          msg_digits = $urandom;
          msg_en = 8'($urandom);
        end
      end else if ($urandom_range(0, 9) == 0) begin
        msg_req = 1'b1;
        msg_digits = $urandom;
        msg_en = 8'($urandom);
      end
      tick();
    end
    reset = 1'b0;
    msg_req = 1'b0;
    msg_clr = 1'b0;
    repeat (20) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
